// File: rtl/audio_session_ctrl.sv
// Session controller for the lab3 audio path: turns key pulses into recorder/player commands
// and arbitrates the single SRAM port between recorder writes and player reads.
module audio_session_ctrl #(
  parameter int unsigned        ADDR_W   = 20,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  input  logic              i_rec_valid,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_play_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_full,
  output logic              o_done
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRec       = 3'd1,
    StRecPause  = 3'd2,
    StPlay      = 3'd3,
    StPlayPause = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic                has_rec_q, has_rec_d;
  logic                full_q, full_d;
  logic                rec_start_q, rec_start_d;
  logic                rec_pause_q, rec_pause_d;
  logic                rec_stop_q, rec_stop_d;
  logic                play_start_q, play_start_d;
  logic                play_pause_q, play_pause_d;
  logic                play_stop_q, play_stop_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                sram_we_n_q, sram_we_n_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   play_data_q, play_data_d;
  logic                play_valid_q, play_valid_d;

  always_comb begin
    state_d      = state_q;
    end_addr_d   = end_addr_q;
    has_rec_d    = has_rec_q;
    full_d       = full_q;
    rec_start_d  = 1'b0;
    rec_pause_d  = 1'b0;
    rec_stop_d   = 1'b0;
    play_start_d = 1'b0;
    play_pause_d = 1'b0;
    play_stop_d  = 1'b0;
    done_d       = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_we_n_d  = 1'b1;
    sram_wdata_d = sram_wdata_q;
    rd_pend_d    = 1'b0;
    play_data_d  = play_data_q;
    play_valid_d = 1'b0;

    // Read issued last cycle: SRAM data is valid now.
    if (rd_pend_q) begin
      play_data_d  = i_sram_rdata;
      play_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_key_rec) begin
          state_d     = StRec;
          rec_start_d = 1'b1;
          end_addr_d  = '0;
          has_rec_d   = 1'b0;
          full_d      = 1'b0;
        end else if (i_key_play && has_rec_q) begin
          state_d      = StPlay;
          play_start_d = 1'b1;
        end
      end
      StRec: begin
        if (i_key_stop) begin
          state_d    = StIdle;
          rec_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d     = StRecPause;
          rec_pause_d = 1'b1;
        end
        if (i_rec_valid) begin
          sram_addr_d  = i_rec_addr;
          sram_wdata_d = i_rec_data;
          sram_we_n_d  = 1'b0;
          end_addr_d   = i_rec_addr;
          has_rec_d    = 1'b1;
          // Memory exhausted: this write lands, then the session closes itself.
          if (i_rec_addr == MAX_ADDR) begin
            full_d      = 1'b1;
            rec_stop_d  = 1'b1;
            rec_pause_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StRecPause: begin
        if (i_key_stop) begin
          state_d    = StIdle;
          rec_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d     = StRec;
          rec_start_d = 1'b1;
        end
      end
      StPlay: begin
        if (i_key_stop) begin
          state_d     = StIdle;
          play_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d      = StPlayPause;
          play_pause_d = 1'b1;
        end
        if (i_play_req) begin
          if (i_play_addr <= end_addr_q) begin
            sram_addr_d = i_play_addr;
            rd_pend_d   = 1'b1;
          end else begin
            done_d       = 1'b1;
            play_stop_d  = 1'b1;
            play_pause_d = 1'b0;
            state_d      = StIdle;
          end
        end
      end
      StPlayPause: begin
        if (i_key_stop) begin
          state_d     = StIdle;
          play_stop_d = 1'b1;
        end else if (i_key_pause) begin
          state_d      = StPlay;
          play_start_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q      <= StIdle;
      end_addr_q   <= '0;
      has_rec_q    <= 1'b0;
      full_q       <= 1'b0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
      done_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_we_n_q  <= 1'b1;
      sram_wdata_q <= '0;
      rd_pend_q    <= 1'b0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      end_addr_q   <= end_addr_d;
      has_rec_q    <= has_rec_d;
      full_q       <= full_d;
      rec_start_q  <= rec_start_d;
      rec_pause_q  <= rec_pause_d;
      rec_stop_q   <= rec_stop_d;
      play_start_q <= play_start_d;
      play_pause_q <= play_pause_d;
      play_stop_q  <= play_stop_d;
      done_q       <= done_d;
      sram_addr_q  <= sram_addr_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_wdata_q <= sram_wdata_d;
      rd_pend_q    <= rd_pend_d;
      play_data_q  <= play_data_d;
      play_valid_q <= play_valid_d;
    end
  end

  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_play_start = play_start_q;
  assign o_play_pause = play_pause_q;
  assign o_play_stop  = play_stop_q;
  assign o_play_data  = play_data_q;
  assign o_play_valid = play_valid_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_we_n  = sram_we_n_q;
  assign o_sram_wdata = sram_wdata_q;
  assign o_state      = state_q;
  assign o_end_addr   = end_addr_q;
  assign o_full       = full_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_audio_session_ctrl.sv
// Bench for audio_session_ctrl: directed session scenarios plus random key/bus traffic,
// all checked cycle by cycle against a session-level reference model with an SRAM model.
module tb_audio_session_ctrl;

  localparam logic [19:0] MaxAddr = 20'hFFFFF;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_key_rec, i_key_play, i_key_pause, i_key_stop;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic        i_rec_valid;
  logic [19:0] i_rec_addr;
  logic [15:0] i_rec_data;
  logic        o_play_start, o_play_pause, o_play_stop;
  logic        i_play_req;
  logic [19:0] i_play_addr;
  logic [15:0] o_play_data;
  logic        o_play_valid;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n;
  logic [15:0] o_sram_wdata;
  logic [15:0] i_sram_rdata;
  logic [2:0]  o_state;
  logic [19:0] o_end_addr;
  logic        o_full, o_done;

  audio_session_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_key_rec    (i_key_rec),
    .i_key_play   (i_key_play),
    .i_key_pause  (i_key_pause),
    .i_key_stop   (i_key_stop),
    .o_rec_start  (o_rec_start),
    .o_rec_pause  (o_rec_pause),
    .o_rec_stop   (o_rec_stop),
    .i_rec_valid  (i_rec_valid),
    .i_rec_addr   (i_rec_addr),
    .i_rec_data   (i_rec_data),
    .o_play_start (o_play_start),
    .o_play_pause (o_play_pause),
    .o_play_stop  (o_play_stop),
    .i_play_req   (i_play_req),
    .i_play_addr  (i_play_addr),
    .o_play_data  (o_play_data),
    .o_play_valid (o_play_valid),
    .o_sram_addr  (o_sram_addr),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_wdata (o_sram_wdata),
    .i_sram_rdata (i_sram_rdata),
    .o_state      (o_state),
    .o_end_addr   (o_end_addr),
    .o_full       (o_full),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Asynchronous SRAM environment: contents follow the DUT's bus.
  bit [15:0] sram_mem [bit [19:0]];
  always @(negedge i_clk) begin
    if (o_sram_we_n === 1'b0) sram_mem[o_sram_addr] = o_sram_wdata;
    if (^o_sram_addr !== 1'bx && sram_mem.exists(o_sram_addr)) i_sram_rdata = sram_mem[o_sram_addr];
    else i_sram_rdata = 16'h0;
  end

  // Reference model: session mode uses the externally visible state codes.
  bit [15:0]   m_mem [bit [19:0]];
  int          m_mode;
  logic [19:0] m_end;
  bit          m_has, m_full;
  bit          m_rs, m_rp, m_rstop, m_ps, m_pp, m_pstop, m_done;
  logic [19:0] m_addr;
  logic [15:0] m_wdata, m_pdata;
  bit          m_we_n, m_pvalid;
  bit          m_rd_pend;
  logic [19:0] m_rd_addr;

  function automatic logic [15:0] mem_rd(input logic [19:0] a);
    return m_mem.exists(a) ? m_mem[a] : 16'h0;
  endfunction

  task automatic model_step();
    {m_rs, m_rp, m_rstop, m_ps, m_pp, m_pstop, m_done, m_pvalid} = '0;
    m_we_n = 1'b1;
    if (i_rst_n) begin
      m_mode = 0; m_end = '0; m_has = 0; m_full = 0;
      m_addr = '0; m_wdata = '0; m_pdata = '0; m_rd_pend = 0;
      return;
    end
    if (m_rd_pend) begin
      m_pdata   = mem_rd(m_rd_addr);
      m_pvalid  = 1;
      m_rd_pend = 0;
    end
    case (m_mode)
      0: begin
        if (i_key_rec) begin
          m_mode = 1; m_rs = 1; m_end = '0; m_has = 0; m_full = 0;
        end else if (i_key_play && m_has) begin
          m_mode = 3; m_ps = 1;
        end
      end
      1: begin
        if (i_rec_valid) begin
          m_addr = i_rec_addr; m_wdata = i_rec_data; m_we_n = 0;
          m_mem[i_rec_addr] = i_rec_data;
          m_end = i_rec_addr; m_has = 1;
        end
        if (i_rec_valid && i_rec_addr == MaxAddr) begin
          m_full = 1; m_rstop = 1; m_mode = 0;
        end else if (i_key_stop) begin
          m_rstop = 1; m_mode = 0;
        end else if (i_key_pause) begin
          m_rp = 1; m_mode = 2;
        end
      end
      2: begin
        if (i_key_stop) begin m_rstop = 1; m_mode = 0; end
        else if (i_key_pause) begin m_rs = 1; m_mode = 1; end
      end
      3: begin
        if (i_play_req && i_play_addr > m_end) begin
          m_done = 1; m_pstop = 1; m_mode = 0;
        end else begin
          if (i_play_req) begin
            m_addr = i_play_addr; m_rd_pend = 1; m_rd_addr = i_play_addr;
          end
          if (i_key_stop) begin m_pstop = 1; m_mode = 0; end
          else if (i_key_pause) begin m_pp = 1; m_mode = 4; end
        end
      end
      4: begin
        if (i_key_stop) begin m_pstop = 1; m_mode = 0; end
        else if (i_key_pause) begin m_ps = 1; m_mode = 3; end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_all();
    check_eq("state", o_state, m_mode);
    check_eq("rec_start", o_rec_start, m_rs);
    check_eq("rec_pause", o_rec_pause, m_rp);
    check_eq("rec_stop", o_rec_stop, m_rstop);
    check_eq("play_start", o_play_start, m_ps);
    check_eq("play_pause", o_play_pause, m_pp);
    check_eq("play_stop", o_play_stop, m_pstop);
    check_eq("done", o_done, m_done);
    check_eq("full", o_full, m_full);
    check_eq("end_addr", o_end_addr, m_end);
    check_eq("sram_we_n", o_sram_we_n, m_we_n);
    check_eq("sram_addr", o_sram_addr, m_addr);
    check_eq("sram_wdata", o_sram_wdata, m_wdata);
    check_eq("play_valid", o_play_valid, m_pvalid);
    check_eq("play_data", o_play_data, m_pdata);
  endtask

  task automatic clear_inputs();
    i_rst_n = 0; i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0;
    i_rec_valid = 0; i_play_req = 0;
  endtask

  // One clock: the model consumes the inputs set before the edge, outputs checked 1 ns after.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    check_all();
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [15:0] scen_data [5];

  initial begin
    scen_data[0] = 16'hF2CF; scen_data[1] = 16'hF64F; scen_data[2] = 16'h83C1;
    scen_data[3] = 16'h9C58; scen_data[4] = 16'h6A4C;
    clear_inputs();
    i_rec_addr = '0; i_rec_data = '0; i_play_addr = '0; i_sram_rdata = '0;

    i_rst_n = 1; tick();
    i_rst_n = 1; tick();

    // Reset held two cycles in the middle of a recording.
    i_key_rec = 1; tick();
    i_rec_valid = 1; i_rec_addr = 20'd7; i_rec_data = 16'h1234; tick();
    i_rst_n = 1; tick();
    i_rst_n = 1; tick();
    check_eq("rst_state", o_state, 0);
    check_eq("rst_we_n", o_sram_we_n, 1);
    check_eq("rst_end", o_end_addr, 0);
    idle(2);

    // Record five samples.
    i_key_rec = 1; tick();
    for (int i = 0; i < 5; i++) begin
      i_rec_valid = 1; i_rec_addr = 20'(i); i_rec_data = scen_data[i]; tick();
      check_eq("wr_we_n", o_sram_we_n, 0);
      check_eq("wr_data", o_sram_wdata, scen_data[i]);
      tick();
    end
    check_eq("end_after_rec", o_end_addr, 4);

    // Pause toggling; writes suppressed while paused.
    i_key_pause = 1; tick(); check_eq("p1_rec_pause", o_rec_pause, 1);
    i_rec_valid = 1; i_rec_addr = 20'd9; i_rec_data = 16'hDEAD; tick();
    check_eq("paused_no_wr", o_sram_we_n, 1);
    tick();
    i_key_pause = 1; tick(); check_eq("p2_rec_start", o_rec_start, 1);
    idle(2);
    i_key_pause = 1; tick(); check_eq("p3_rec_pause", o_rec_pause, 1);
    idle(2);
    check_eq("paused_state", o_state, 2);

    // Stop, then play back through the end of the recording.
    i_key_stop = 1; tick();
    i_key_play = 1; tick();
    check_eq("play_start", o_play_start, 1);
    for (int i = 0; i < 5; i++) begin
      i_play_req = 1; i_play_addr = 20'(i); tick();
      tick();
      check_eq("pb_valid", o_play_valid, 1);
      check_eq("pb_data", o_play_data, scen_data[i]);
      tick();
    end
    i_play_req = 1; i_play_addr = 20'd5; tick();
    check_eq("pb_done", o_done, 1);
    check_eq("pb_stop", o_play_stop, 1);
    check_eq("pb_idle", o_state, 0);
    idle(2);

    // Simultaneous keys.
    i_key_rec = 1; i_key_stop = 1; tick();
    check_eq("k_rec_start", o_rec_start, 1);
    i_key_stop = 1; i_key_pause = 1; tick();
    check_eq("k_rec_stop", o_rec_stop, 1);
    check_eq("k_no_pause", o_rec_pause, 0);
    idle(2);

    // Recording into the last address.
    i_key_rec = 1; tick();
    i_rec_valid = 1; i_rec_addr = MaxAddr; i_rec_data = 16'hABCD; tick();
    check_eq("max_we_n", o_sram_we_n, 0);
    check_eq("max_full", o_full, 1);
    check_eq("max_stop", o_rec_stop, 1);
    check_eq("max_idle", o_state, 0);
    idle(2);
    i_rst_n = 1; tick();
    i_key_play = 1; tick();
    check_eq("noplay_start", o_play_start, 0);
    check_eq("noplay_state", o_state, 0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      i_rst_n     = ($urandom_range(0, 499) == 0);
      i_key_rec   = ($urandom_range(0, 15) == 0);
      i_key_play  = ($urandom_range(0, 7) == 0);
      i_key_pause = ($urandom_range(0, 15) == 0);
      i_key_stop  = ($urandom_range(0, 31) == 0);
      i_rec_valid = $urandom_range(0, 1) == 1;
      i_rec_addr  = ($urandom_range(0, 63) == 0) ? MaxAddr : 20'($urandom_range(0, 15));
      i_rec_data  = 16'($urandom);
      i_play_req  = ($urandom_range(0, 2) == 0);
      i_play_addr = 20'($urandom_range(0, 18));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_session_ctrl.md
Name: audio_session_ctrl

Overview:
- Top-level session controller for the lab3 audio recorder/player path.
- Converts debounced key pulses into start, pause and stop pulses for the recorder and the player.
- Arbitrates the single SRAM port between recorder writes and player reads, and tracks the last recorded address.
- Sits between the key/debounce logic and the recorder, player and SRAM interface, clocked on the codec bit clock.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, audio sample width
MAX_ADDR, 20'hFFFFF, last usable SRAM address

Ports:
i_clk  in  1  codec bit clock; single clock for the whole block
i_rst_n  in  1  synchronous, active-high reset (1 = reset)
i_key_rec  in  1  one-cycle pulse: start a new recording
i_key_play  in  1  one-cycle pulse: start playback
i_key_pause  in  1  one-cycle pulse: toggle pause/resume
i_key_stop  in  1  one-cycle pulse: stop
o_rec_start  out  1  one-cycle pulse to recorder (start or resume)
o_rec_pause  out  1  one-cycle pulse to recorder
o_rec_stop  out  1  one-cycle pulse to recorder
i_rec_valid  in  1  recorder has a completed sample
i_rec_addr  in  ADDR_W  recorder write address
i_rec_data  in  DATA_W  recorder sample
o_play_start  out  1  one-cycle pulse to player (start or resume)
o_play_pause  out  1  one-cycle pulse to player
o_play_stop  out  1  one-cycle pulse to player
i_play_req  in  1  player requests one sample
i_play_addr  in  ADDR_W  player read address
o_play_data  out  DATA_W  sample returned to player
o_play_valid  out  1  o_play_data valid, one-cycle pulse
o_sram_addr  out  ADDR_W  SRAM address
o_sram_we_n  out  1  0 = write, 1 = read
o_sram_wdata  out  DATA_W  SRAM write data
i_sram_rdata  in  DATA_W  SRAM read data
o_state  out  3  current FSM state code
o_end_addr  out  ADDR_W  last written address
o_full  out  1  recording hit MAX_ADDR
o_done  out  1  one-cycle pulse: playback reached the end

Behaviour:

Reset:
- All outputs and registers go to 0, except o_sram_we_n = 1.
- has_rec = 0; state = IDLE.
- Reset mid-operation aborts the session in the same way, with no stop pulses emitted.

States and codes: IDLE = 0, REC = 1, REC_PAUSE = 2, PLAY = 3, PLAY_PAUSE = 4.

Key priority on the same cycle: stop > pause > rec > play. Only the highest-priority key acts; the others are dropped.

Transitions (all command pulses are registered, asserted the cycle after the key):
- IDLE + rec -> REC: o_rec_start; end_addr = 0; has_rec = 0; o_full = 0.
- IDLE + play with has_rec = 1 -> PLAY: o_play_start; o_done = 0. Play with has_rec = 0 is ignored.
- REC + pause -> REC_PAUSE: o_rec_pause.
- REC_PAUSE + pause -> REC: o_rec_start.
- PLAY + pause -> PLAY_PAUSE: o_play_pause.
- PLAY_PAUSE + pause -> PLAY: o_play_start.
- REC or REC_PAUSE + stop -> IDLE: o_rec_stop.
- PLAY or PLAY_PAUSE + stop -> IDLE: o_play_stop.
- Rec or play pressed in any non-IDLE state is ignored. Pause or stop in IDLE is ignored.

Recording write (REC only; i_rec_valid is ignored in every other state):
- Valid at cycle t -> at t+1: o_sram_addr = i_rec_addr, o_sram_wdata = i_rec_data, o_sram_we_n = 0 for exactly one cycle.
- end_addr <= i_rec_addr; has_rec <= 1.
- Write to MAX_ADDR: that write still completes, then the same cycle sets o_full = 1, emits o_rec_stop, and goes to IDLE.

Playback read (PLAY only; requests in other states are dropped with no o_play_valid):
- Request at cycle t with i_play_addr <= end_addr -> o_sram_addr = i_play_addr at t+1 with o_sram_we_n = 1.
- i_sram_rdata is captured at t+2 into o_play_data, with o_play_valid = 1 at t+2.
- Request with i_play_addr > end_addr -> no read issued; o_done pulse and o_play_stop at t+1; state -> IDLE.

Bus and output rules:
- Idle bus: we_n = 1; address and wdata hold their last values.
- Recorder and player are never active together, so no bus conflict exists. A recorder valid and a player request on the same cycle are resolved by state.
- o_state, o_end_addr and o_full are registered.

Test Plan:
1. Reset held 2 cycles during REC -> o_state = 0, o_sram_we_n = 1, no pulses, o_end_addr = 0.
2. rec key, then i_rec_valid with addr 0..4 and data 16'hF2CF, 16'hF64F, 16'h83C1, 16'h9C58, 16'h6A4C -> 5 single-cycle writes, each one cycle after its valid, with matching data; o_end_addr = 4.
3. pause, pause, pause (each 3 cycles apart) during REC -> o_rec_pause, o_rec_start, o_rec_pause; i_rec_valid while paused produces no write; o_state ends at 2.
4. stop, then play; player requests addr 0..5 -> addr 0..4 return the scenario-2 data with o_play_valid 2 cycles after each request; addr 5 -> o_done, o_play_stop, o_state = 0.
5. Keys rec + stop on the same cycle in IDLE -> rec acts (stop ignored in IDLE); next cycle stop + pause in REC -> only o_rec_stop.
6. Recording with i_rec_addr = MAX_ADDR -> write issued, o_full = 1, o_rec_stop, IDLE; play from reset state with has_rec = 0 -> ignored.
